des_decrypt_key_scheduler: RTL and testbench

Iterative DES key schedule for the decryption datapath. Delivers the 16 round keys in reverse order, K16 first and K1 last, one key per valid/ready handshake. Rotates the C/D halves right, so no 16-key array is stored. Sits beside the encrypt-side round key generator and feeds the round function one key per round.

---
 rtl/des_decrypt_key_scheduler_pkg.sv | 81 ++++++++
 rtl/des_decrypt_key_scheduler_if.sv | 34 +++
 rtl/des_decrypt_key_scheduler_pc2.sv | 19 +
 rtl/des_decrypt_key_scheduler.sv | 113 +++++++++++
 tb/tb_des_decrypt_key_scheduler.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/des_decrypt_key_scheduler_pkg.sv
// Shared definitions for the DES key schedulers: permutation tables,
// per-round shift schedule, state encoding and rotate/PC-1 helpers.
// Optional feature macro used by the scheduler: DES_KS_ENC_EN.
package des_ks_pkg;

  localparam int KEY_W  = 64;
  localparam int RK_W   = 48;
  localparam int ROUNDS = 16;
  localparam int CD_W   = 56;
  localparam int HALF_W = 28;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ks_state_e;

  // PC-1 source positions in DES numbering (bit 1 = MSB of the key)
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2 source positions in DES numbering (bit 1 = MSB of CD)
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-shift amount applied to C/D when forming round n
  localparam logic [1:0] SHIFT_SCHED [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = 56'd0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
    end
    return cd;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  // Shift amount for round n; out-of-range rounds shift by zero
  function automatic logic [1:0] shift_amt(input logic [4:0] n);
    if (n >= 5'd1 && n <= 5'd16) begin
      return SHIFT_SCHED[n];
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/des_decrypt_key_scheduler_if.sv
// Key load / round-key handshake bundle between the scheduler (slave)
// and its user (master). enc_mode exists only with DES_KS_ENC_EN.
interface des_decrypt_key_scheduler_if;
  import des_ks_pkg::*;

  logic              key_load;
  logic [KEY_W-1:0]  key_in;
`ifdef DES_KS_ENC_EN
  logic              enc_mode;
`endif
  logic              key_busy;
  logic              rk_valid;
  logic              rk_ready;
  logic [RK_W-1:0]   round_key;
  logic [3:0]        rk_num;
  logic              sched_done;

  modport master (
`ifdef DES_KS_ENC_EN
    output enc_mode,
`endif
    output key_load, key_in, rk_ready,
    input  key_busy, rk_valid, round_key, rk_num, sched_done
  );

  modport slave (
`ifdef DES_KS_ENC_EN
    input  enc_mode,
`endif
    input  key_load, key_in, rk_ready,
    output key_busy, rk_valid, round_key, rk_num, sched_done
  );

endinterface

// File: rtl/des_decrypt_key_scheduler_pc2.sv
// PC-2 compression permutation, 56-bit CD to 48-bit round key.
// Pure wiring; shared with the encrypt-side key generator.
module des_ks_pc2
  import des_ks_pkg::*;
(
  input  logic [CD_W-1:0] cd_i,
  output logic [RK_W-1:0] rk_o
);

  // CD positions PC-2 drops (DES bits 9,18,22,25,35,38,43,54)
  logic unused_cd_s;
  assign unused_cd_s = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                         cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

  for (genvar i = 0; i < RK_W; i++) begin : g_pc2
    assign rk_o[RK_W-1-i] = cd_i[CD_W - PC2_TAB[i]];
  end

endmodule

// File: rtl/des_decrypt_key_scheduler.sv
// Iterative DES key schedule, decrypt order (K16 first, K1 last).
// C/D are rotated right each handshake so only the 56-bit CD state is kept.
// Optional DES_KS_ENC_EN adds enc_mode for K1..K16 order with left rotates.
module des_decrypt_key_scheduler
  import des_ks_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  des_decrypt_key_scheduler_if.slave    bus
);

  ks_state_e         state_q, state_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic [3:0]        rk_num_q, rk_num_d;
  logic              sched_done_q, sched_done_d;

  logic              handshake_s;
  logic              last_s;
  logic [CD_W-1:0]   pc1_s;
  logic [1:0]        shamt_s;
  logic [CD_W-1:0]   cd_step_s;
  logic [3:0]        rk_num_step_s;
  logic [RK_W-1:0]   round_key_s;

  assign pc1_s       = pc1(bus.key_in);
  assign handshake_s = (state_q == EMIT) & bus.rk_ready;

`ifdef DES_KS_ENC_EN
  logic enc_q, enc_d;

  assign last_s        = enc_q ? (rk_num_q == 4'd15) : (rk_num_q == 4'd0);
  assign shamt_s       = enc_q ? shift_amt({1'b0, rk_num_q} + 5'd2)
                               : shift_amt({1'b0, rk_num_q} + 5'd1);
  assign cd_step_s     = enc_q ? {rotl28(cd_q[55:28], shamt_s), rotl28(cd_q[27:0], shamt_s)}
                               : {rotr28(cd_q[55:28], shamt_s), rotr28(cd_q[27:0], shamt_s)};
  assign rk_num_step_s = enc_q ? (rk_num_q + 4'd1) : (rk_num_q - 4'd1);
`else
  assign last_s        = (rk_num_q == 4'd0);
  assign shamt_s       = shift_amt({1'b0, rk_num_q} + 5'd1);
  assign cd_step_s     = {rotr28(cd_q[55:28], shamt_s), rotr28(cd_q[27:0], shamt_s)};
  assign rk_num_step_s = rk_num_q - 4'd1;
`endif

  // Next-state: key_load restarts from any state and beats a handshake
  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    rk_num_d     = rk_num_q;
    sched_done_d = 1'b0;
`ifdef DES_KS_ENC_EN
    enc_d        = enc_q;
`endif
    if (bus.key_load) begin
      state_d = EMIT;
`ifdef DES_KS_ENC_EN
      enc_d   = bus.enc_mode;
      if (bus.enc_mode) begin
        cd_d     = {rotl28(pc1_s[55:28], 2'd1), rotl28(pc1_s[27:0], 2'd1)};
        rk_num_d = 4'd0;
      end else begin
        cd_d     = pc1_s;
        rk_num_d = 4'd15;
      end
`else
      cd_d     = pc1_s;
      rk_num_d = 4'd15;
`endif
    end else if (handshake_s) begin
      if (last_s) begin
        state_d      = IDLE;
        sched_done_d = 1'b1;
      end else begin
        cd_d     = cd_step_s;
        rk_num_d = rk_num_step_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, CD halves, key index and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cd_q         <= 56'd0;
      rk_num_q     <= 4'd0;
      sched_done_q <= 1'b0;
`ifdef DES_KS_ENC_EN
      enc_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      rk_num_q     <= rk_num_d;
      sched_done_q <= sched_done_d;
`ifdef DES_KS_ENC_EN
      enc_q        <= enc_d;
`endif
    end
  end

  des_ks_pc2 u_pc2 (
    .cd_i (cd_q),
    .rk_o (round_key_s)
  );

  assign bus.round_key  = round_key_s;
  assign bus.rk_num     = rk_num_q;
  assign bus.rk_valid   = (state_q == EMIT);
  assign bus.key_busy   = (state_q == EMIT);
  assign bus.sched_done = sched_done_q;

endmodule

// File: tb/tb_des_decrypt_key_scheduler.sv
// Scoreboard bench for des_decrypt_key_scheduler: stimulus pushes the
// expected key sequence, a negedge monitor pops and compares on handshakes.
module tb_des_decrypt_key_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  bit   exp_done = 1'b0;
  logic [51:0] exp_q [$];
  logic [51:0] mon_ent;
  bit   enc_sel = 1'b0;

  // K1..K16 for key 133457799BBCDFF1
  localparam logic [47:0] KTAB [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  always #5 clk = ~clk;

  des_decrypt_key_scheduler_if bus ();

  des_decrypt_key_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_sched(input bit zero_key, input bit enc);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] r;
      r = enc ? 4'(i) : 4'(15 - i);
      exp_q.push_back({r, zero_key ? 48'h0 : KTAB[r]});
    end
  endtask

  // Called at posedge+1; key_load is held for exactly this cycle
  task automatic load_now(input logic [63:0] k, input bit zero_key, input bit enc);
    exp_q.delete();
    push_sched(zero_key, enc);
    bus.key_in   = k;
    bus.key_load = 1'b1;
`ifdef DES_KS_ENC_EN
    bus.enc_mode = enc;
`endif
    @(posedge clk); #1;
    bus.key_load = 1'b0;
  endtask

  task automatic wait_num(input logic [3:0] n);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk); #1;
      if (bus.rk_valid && bus.rk_num == n) hit = 1'b1;
    end
    check("wait_rk_num", 64'(hit), 64'd1);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Monitor: sched_done timing, busy/valid vs scoreboard, key/index on display
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done = 1'b0;
    end else begin
      check("sched_done", 64'(bus.sched_done), 64'(exp_done));
      exp_done = 1'b0;
      if (!bus.key_load) begin
        check("key_busy", 64'(bus.key_busy), 64'(exp_q.size() != 0));
        check("rk_valid", 64'(bus.rk_valid), 64'(exp_q.size() != 0));
        if (bus.rk_valid && exp_q.size() != 0) begin
          mon_ent = exp_q[0];
          check("rk_num", 64'(bus.rk_num), 64'(mon_ent[51:48]));
          check("round_key", 64'(bus.round_key), 64'(mon_ent[47:0]));
          if (bus.rk_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int hs0;
    bus.key_load = 1'b0;
    bus.key_in   = 64'd0;
    bus.rk_ready = 1'b0;
`ifdef DES_KS_ENC_EN
    bus.enc_mode = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    check("reset_rk_valid", 64'(bus.rk_valid), 64'd0);
    check("reset_key_busy", 64'(bus.key_busy), 64'd0);
    check("reset_sched_done", 64'(bus.sched_done), 64'd0);
    check("reset_round_key", 64'(bus.round_key), 64'd0);
    check("reset_rk_num", 64'(bus.rk_num), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;

    // Decrypt order, always ready
    bus.rk_ready = 1'b1;
    @(posedge clk); #1;
    hs0 = hs_cnt;
    load_now(KEY_A, 1'b0, 1'b0);
    wait_drain();
    check("hs_count_plain", 64'(hs_cnt - hs0), 64'd16);

    // Backpressure with 5-cycle stalls
    hs0 = hs_cnt;
    load_now(KEY_A, 1'b0, 1'b0);
    for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.rk_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
      end
      bus.rk_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.rk_ready = 1'b1;
    wait_drain();
    check("hs_count_stall", 64'(hs_cnt - hs0), 64'd16);

    // Abort at rk_num=9 with the all-zero key
    load_now(KEY_A, 1'b0, 1'b0);
    wait_num(4'd9);
    load_now(64'd0, 1'b1, 1'b0);
    wait_drain();

    // Reset mid-schedule at rk_num=7
    load_now(KEY_A, 1'b0, 1'b0);
    wait_num(4'd7);
    @(negedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_rk_valid", 64'(bus.rk_valid), 64'd0);
    check("midrst_key_busy", 64'(bus.key_busy), 64'd0);
    check("midrst_round_key", 64'(bus.round_key), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("postrst_key_busy", 64'(bus.key_busy), 64'd0);
    check("postrst_rk_valid", 64'(bus.rk_valid), 64'd0);

    // key_load together with the final handshake
    load_now(KEY_A, 1'b0, 1'b0);
    wait_num(4'd0);
    load_now(64'd0, 1'b1, 1'b0);
    check("restart_no_done", 64'(bus.sched_done), 64'd0);
    check("restart_rk_num", 64'(bus.rk_num), 64'd15);
    wait_drain();

`ifdef DES_KS_ENC_EN
    // Encrypt order K1..K16
    enc_sel = 1'b1;
    load_now(KEY_A, 1'b0, enc_sel);
    wait_drain();
    enc_sel = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
